// File: rtl/add_pkg.sv
// Shared constants and saturation helpers for the pipelined adder family.
package add_pkg;

  localparam int ADD_MODE_WRAP  = 0;
  localparam int ADD_MODE_USAT  = 1;
  localparam int ADD_MODE_SSAT  = 2;

  localparam int ADD_STAGES_MIN = 1;
  localparam int ADD_STAGES_MAX = 4;

  // Helpers return a wide vector; callers truncate to their own width.
  localparam int ADD_MAX_W      = 128;

  function automatic logic [ADD_MAX_W-1:0] add_umax(input int w);
    logic [ADD_MAX_W-1:0] r;
    for (int i = 0; i < ADD_MAX_W; i++) r[i] = (i < w);
    return r;
  endfunction

  function automatic logic [ADD_MAX_W-1:0] add_smax(input int w);
    logic [ADD_MAX_W-1:0] r;
    for (int i = 0; i < ADD_MAX_W; i++) r[i] = (i < w - 1);
    return r;
  endfunction

  function automatic logic [ADD_MAX_W-1:0] add_smin(input int w);
    logic [ADD_MAX_W-1:0] r;
    for (int i = 0; i < ADD_MAX_W; i++) r[i] = (i == w - 1);
    return r;
  endfunction

endpackage

// File: rtl/add_slice.sv
// One carry-chain slice: W-bit add with carry in and carry out.
module add_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

endmodule

// File: rtl/add_pipe.sv
// Pipelined adder: DATAWIDTH carry chain split over STAGES registered slices, valid/ready on both sides.
// Define ADD_PIPE_OVF_EN to add the ovf output that travels with each result.
module add_pipe
  import add_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int STAGES    = 2,
  parameter int MODE      = 0
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] sum,
  output logic                 cout,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef ADD_PIPE_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int W = DATAWIDTH / STAGES;
  localparam int L = STAGES - 1;

  localparam logic [DATAWIDTH-1:0] UMAX = DATAWIDTH'(add_umax(DATAWIDTH));
  localparam logic [DATAWIDTH-1:0] SMAX = DATAWIDTH'(add_smax(DATAWIDTH));
  localparam logic [DATAWIDTH-1:0] SMIN = DATAWIDTH'(add_smin(DATAWIDTH));

  if (STAGES < ADD_STAGES_MIN || STAGES > ADD_STAGES_MAX) begin : g_bad_stages
    $error("add_pipe: STAGES out of range");
  end
  if (DATAWIDTH % STAGES != 0) begin : g_bad_width
    $error("add_pipe: DATAWIDTH must be a multiple of STAGES");
  end
  if (DATAWIDTH > ADD_MAX_W) begin : g_too_wide
    $error("add_pipe: DATAWIDTH exceeds helper width");
  end

  logic [STAGES-1:0]                r_v;
  logic [STAGES-1:0]                r_c;
  logic [STAGES-1:0][DATAWIDTH-1:0] r_a;
  logic [STAGES-1:0][DATAWIDTH-1:0] r_b;
  logic [STAGES-1:0][DATAWIDTH-1:0] r_s;

  logic [STAGES-1:0]                w_ld;
  logic [STAGES-1:0]                w_in_v;
  logic [STAGES-1:0]                w_src_c;
  logic [STAGES-1:0]                w_slice_co;
  logic [STAGES-1:0][DATAWIDTH-1:0] w_src_a;
  logic [STAGES-1:0][DATAWIDTH-1:0] w_src_b;
  logic [STAGES-1:0][DATAWIDTH-1:0] w_src_s;
  logic [STAGES-1:0][DATAWIDTH-1:0] w_s_nxt;
  logic [STAGES-1:0][W-1:0]         w_slice_sum;
  logic [DATAWIDTH-1:0]             w_raw;
  logic [DATAWIDTH-1:0]             w_sat;
  logic                             w_ovf_s;
  logic                             w_ovf_sel;

  // A stage can load unless it and every stage after it are full with the output stalled.
  always_comb begin
    logic w_full;
    w_ld = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_full = 1'b1;
      for (int j = k; j < STAGES; j++) w_full = w_full & r_v[j];
      w_ld[k] = out_ready || !w_full;
    end
  end

  assign in_ready = Rst_n && w_ld[0];

  always_comb begin
    w_src_a[0] = a;
    w_src_b[0] = b;
    w_src_s[0] = '0;
    w_src_c[0] = 1'b0;
    w_in_v[0]  = in_valid && in_ready;
    for (int k = 1; k < STAGES; k++) begin
      w_src_a[k] = r_a[k-1];
      w_src_b[k] = r_b[k-1];
      w_src_s[k] = r_s[k-1];
      w_src_c[k] = r_c[k-1];
      w_in_v[k]  = r_v[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    add_slice #(.W(W)) u_slice (
      .i_a    (w_src_a[k][k*W +: W]),
      .i_b    (w_src_b[k][k*W +: W]),
      .i_cin  (w_src_c[k]),
      .o_sum  (w_slice_sum[k]),
      .o_cout (w_slice_co[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_s_nxt[k]           = w_src_s[k];
      w_s_nxt[k][k*W +: W] = w_slice_sum[k];
    end
    w_raw     = w_s_nxt[L];
    w_ovf_s   = (w_src_a[L][DATAWIDTH-1] == w_src_b[L][DATAWIDTH-1]) &&
                (w_raw[DATAWIDTH-1] != w_src_a[L][DATAWIDTH-1]);
    w_sat     = w_raw;
    w_ovf_sel = w_slice_co[L];
    case (MODE)
      ADD_MODE_USAT: begin
        if (w_slice_co[L]) w_sat = UMAX;
      end
      ADD_MODE_SSAT: begin
        w_ovf_sel = w_ovf_s;
        if (w_ovf_s) w_sat = w_src_a[L][DATAWIDTH-1] ? SMIN : SMAX;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_v <= '0;
      r_c <= '0;
      r_a <= '0;
      r_b <= '0;
      r_s <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_ld[k]) begin
          r_v[k] <= w_in_v[k];
          if (w_in_v[k]) begin
            r_a[k] <= w_src_a[k];
            r_b[k] <= w_src_b[k];
            r_c[k] <= w_slice_co[k];
            r_s[k] <= (k == L) ? w_sat : w_s_nxt[k];
          end
        end
      end
    end
  end

  assign sum       = r_s[L];
  assign cout      = r_c[L];
  assign out_valid = r_v[L];

`ifdef ADD_PIPE_OVF_EN
  logic r_ovf;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_ld[L] && w_in_v[L]) begin
      r_ovf <= w_ovf_sel;
    end
  end

  assign ovf = r_ovf;
`endif

  // Already-consumed operand bits and the last stage's operand copy are never read.
  logic w_unused;
  assign w_unused = ^{r_a, r_b, w_src_a, w_src_b, w_ovf_s, w_ovf_sel};

endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe: three 8-bit/2-stage DUTs (one per MODE) on a shared stream,
// plus a 16-bit/4-stage signed-saturate DUT under random backpressure.
module tb_add_pipe;

  logic        clk;
  logic        rst_n;
  logic [7:0]  a, b;
  logic        in_valid, out_ready;
  logic        in_ready0, in_ready1, in_ready2;
  logic [7:0]  sum0, sum1, sum2;
  logic        cout0, cout1, cout2;
  logic        out_valid0, out_valid1, out_valid2;
  logic [15:0] a3, b3, s3;
  logic        iv3, ir3, c3, ov3, or3;
  logic        rnd_phase;
`ifdef ADD_PIPE_OVF_EN
  logic        ovf0, ovf1, ovf2, ovf3;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop0   = 0;
  logic [33:0] q0[$], q1[$], q2[$], q3[$];

  add_pipe #(.DATAWIDTH(8), .STAGES(2), .MODE(0)) u_dut0 (
    .Clk(clk), .Rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready0),
    .sum(sum0), .cout(cout0), .out_valid(out_valid0), .out_ready(out_ready)
`ifdef ADD_PIPE_OVF_EN
    , .ovf(ovf0)
`endif
  );
  add_pipe #(.DATAWIDTH(8), .STAGES(2), .MODE(1)) u_dut1 (
    .Clk(clk), .Rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready1),
    .sum(sum1), .cout(cout1), .out_valid(out_valid1), .out_ready(out_ready)
`ifdef ADD_PIPE_OVF_EN
    , .ovf(ovf1)
`endif
  );
  add_pipe #(.DATAWIDTH(8), .STAGES(2), .MODE(2)) u_dut2 (
    .Clk(clk), .Rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready2),
    .sum(sum2), .cout(cout2), .out_valid(out_valid2), .out_ready(out_ready)
`ifdef ADD_PIPE_OVF_EN
    , .ovf(ovf2)
`endif
  );
  add_pipe #(.DATAWIDTH(16), .STAGES(4), .MODE(2)) u_dut3 (
    .Clk(clk), .Rst_n(rst_n), .a(a3), .b(b3), .in_valid(iv3), .in_ready(ir3),
    .sum(s3), .cout(c3), .out_valid(ov3), .out_ready(or3)
`ifdef ADD_PIPE_OVF_EN
    , .ovf(ovf3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {ovf, cout, sum} from a whole-width add, independent of slicing.
  function automatic logic [33:0] model(input int mode, input int dw, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [31:0] mask, raw;
    logic [32:0] full;
    logic c, sov, xs;
    mask = (32'd1 << dw) - 32'd1;
    full = {1'b0, x & mask} + {1'b0, y & mask};
    raw  = full[31:0] & mask;
    c    = full[dw];
    xs   = x[dw-1];
    sov  = (xs == y[dw-1]) && (raw[dw-1] != xs);
    case (mode)
      0:       return {c, c, raw};
      1:       return {c, c, c ? mask : raw};
      default: return {sov, c, sov ? (xs ? (32'd1 << (dw - 1)) : (mask >> 1)) : raw};
    endcase
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the pair.
  task automatic send(input logic [7:0] x, input logic [7:0] y);
    int cnt;
    a = x;
    b = y;
    in_valid = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!(in_ready0 && in_ready1 && in_ready2) && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) chk("send_accept_timeout", in_ready0, 1);
    else begin
      q0.push_back(model(0, 8, 32'(x), 32'(y)));
      q1.push_back(model(1, 8, 32'(x), 32'(y)));
      q2.push_back(model(2, 8, 32'(x), 32'(y)));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [33:0] e;
    if (out_valid0 && out_ready) begin
      if (q0.size() == 0) chk("d0_spurious", out_valid0, 0);
      else begin
        e = q0.pop_front();
        chk("d0_sum", 32'(sum0), e[31:0]);
        chk("d0_cout", 32'(cout0), 32'(e[32]));
`ifdef ADD_PIPE_OVF_EN
        chk("d0_ovf", 32'(ovf0), 32'(e[33]));
`endif
        n_pop0++;
      end
    end
    if (out_valid1 && out_ready) begin
      if (q1.size() == 0) chk("d1_spurious", out_valid1, 0);
      else begin
        e = q1.pop_front();
        chk("d1_sum", 32'(sum1), e[31:0]);
        chk("d1_cout", 32'(cout1), 32'(e[32]));
`ifdef ADD_PIPE_OVF_EN
        chk("d1_ovf", 32'(ovf1), 32'(e[33]));
`endif
      end
    end
    if (out_valid2 && out_ready) begin
      if (q2.size() == 0) chk("d2_spurious", out_valid2, 0);
      else begin
        e = q2.pop_front();
        chk("d2_sum", 32'(sum2), e[31:0]);
        chk("d2_cout", 32'(cout2), 32'(e[32]));
`ifdef ADD_PIPE_OVF_EN
        chk("d2_ovf", 32'(ovf2), 32'(e[33]));
`endif
      end
    end
    if (ov3 && or3) begin
      if (q3.size() == 0) chk("d3_spurious", ov3, 0);
      else begin
        e = q3.pop_front();
        chk("d3_sum", 32'(s3), e[31:0]);
        chk("d3_cout", 32'(c3), 32'(e[32]));
`ifdef ADD_PIPE_OVF_EN
        chk("d3_ovf", 32'(ovf3), 32'(e[33]));
`endif
      end
    end
  end

  initial begin
    or3 = 1'b1;
    forever begin
      @(posedge clk);
      #1 or3 = rnd_phase ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_before;
    int cnt;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;
    iv3 = 1'b0;
    a3 = '0;
    b3 = '0;
    rnd_phase = 1'b0;

    #3;
    chk("rst_in_ready", in_ready0, 0);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_sum", 32'(sum0), 0);
    #9 rst_n = 1'b1;
    #1 chk("rel_in_ready", in_ready0, 1);
    @(posedge clk);
    #1;

    // Latency: out_valid two cycles after the accept cycle.
    send(8'd10, 8'd5);
    chk("lat_c1_valid", out_valid0, 0);
    @(posedge clk);
    #1;
    chk("lat_c2_valid", out_valid0, 1);
    chk("lat_sum", 32'(sum0), 32'd15);
    chk("lat_cout", 32'(cout0), 0);

    // Mode corners, streamed back-to-back through all three modes.
    send(8'd200, 8'd100);
    send(8'd100, 8'd100);
    send(8'd156, 8'd156);
    send(8'd50,  8'd236);
    send(8'd127, 8'd1);
    send(8'd3,   8'd4);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("drain_q0", q0.size(), 0);
    chk("drain_q2", q2.size(), 0);

    // Backpressure: fill, hold, then release.
    out_ready = 1'b0;
    send(8'd1, 8'd1);
    send(8'd2, 8'd2);
    chk("bp_in_ready_low", in_ready0, 0);
    chk("bp_out_valid", out_valid0, 1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("bp_hold_sum", 32'(sum0), 32'd2);
    chk("bp_hold_ready", in_ready0, 0);
    n_before = n_pop0;
    out_ready = 1'b1;
    send(8'd3, 8'd3);
    chk("bp_nogap1", out_valid0, 1);
    send(8'd4, 8'd4);
    chk("bp_nogap2", out_valid0, 1);
    @(posedge clk);
    #1 chk("bp_nogap3", out_valid0, 1);
    @(posedge clk);
    #1;
    chk("bp_pops", n_pop0 - n_before, 4);
    chk("bp_empty", out_valid0, 0);

    // Reset with two results in flight.
    out_ready = 1'b0;
    send(8'd7, 8'd7);
    send(8'd9, 8'd9);
    chk("mid_pre_valid", out_valid0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_out_valid", out_valid0, 0);
    chk("mid_sum", 32'(sum0), 0);
    chk("mid_in_ready", in_ready0, 0);
    q0.delete();
    q1.delete();
    q2.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("mid_rel_ready", in_ready0, 1);
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("mid_no_stale", out_valid0, 0);

    // Wide pipe under random output stalls.
    rnd_phase = 1'b1;
    for (int i = 0; i < 60; i++) begin
      case (i)
        0:       begin a3 = 16'h7FFF; b3 = 16'h0001; end
        1:       begin a3 = 16'h8000; b3 = 16'hFFFF; end
        2:       begin a3 = 16'h0FFF; b3 = 16'h0001; end
        default: begin a3 = 16'($urandom); b3 = 16'($urandom); end
      endcase
      iv3 = 1'b1;
      cnt = 0;
      @(negedge clk);
      while (!ir3 && cnt < 100) begin
        @(negedge clk);
        cnt++;
      end
      if (cnt >= 100) chk("d3_accept_timeout", ir3, 1);
      else q3.push_back(model(2, 16, 32'(a3), 32'(b3)));
      @(posedge clk);
      #1 iv3 = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_phase = 1'b0;
    cnt = 0;
    while (q3.size() != 0 && cnt < 40) begin
      @(posedge clk);
      #1 cnt++;
    end
    chk("d3_drain", q3.size(), 0);
    chk("d3_idle", ov3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
